// File: rtl/ss_key_detect_if.sv
// CPU bus snoop bundle: one completed CPU access per bus_act strobe.
// Latency: n/a (wires only).
// Backpressure: none; the snooper never stalls the CPU bus.
// Ports: bus_act (access complete), cpu_addr[15:0], cpu_rw (1=read), cpu_dat[7:0].
interface ss_key_detect_if;
   logic        bus_act;
   logic [15:0] cpu_addr;
   logic        cpu_rw;
   logic [7:0]  cpu_dat;

   modport master (output bus_act, output cpu_addr, output cpu_rw, output cpu_dat);
   modport slave  (input  bus_act, input  cpu_addr, input  cpu_rw, input  cpu_dat);
endinterface

// File: rtl/ss_key_detect.sv
// Snoops $4016 pad traffic to rebuild the P1 button byte; fires save/load/menu on held combos or debounced button.
// Latency: joy_state/joy_valid 1 clk after the 8th read; req_* 1 clk after the joy_valid that completes the hold.
// Backpressure: none; passive snooper, req_* are single-cycle pulses the consumer must catch.
// Ports: clk, rst_n (sync, active low); bus (ss_key_detect_if.slave: bus_act/cpu_addr/cpu_rw/cpu_dat);
//        ss_key_save/load/menu combo masks, ct_ss_on, ct_ss_btn, ss_btn (async);
//        joy_state, joy_valid, req_save, req_load, req_menu.
module ss_key_detect #(
   parameter int          HOLD_FRAMES = 4,
   parameter logic [15:0] DEB_CYC     = 16'd50000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   ss_key_detect_if.slave          bus,
   input  logic [7:0]              ss_key_save,
   input  logic [7:0]              ss_key_load,
   input  logic [7:0]              ss_key_menu,
   input  logic                    ct_ss_on,
   input  logic                    ct_ss_btn,
   input  logic                    ss_btn,
   output logic [7:0]              joy_state,
   output logic                    joy_valid,
   output logic                    req_save,
   output logic                    req_load,
   output logic                    req_menu
);

   typedef enum logic [1:0] {ST_IDLE, ST_STRB, ST_SHIFT} pad_st_e;
   typedef enum logic [1:0] {K_NONE, K_MENU, K_SAVE, K_LOAD} key_e;

   localparam logic [3:0] HOLD_N = 4'(HOLD_FRAMES);

   // pad reconstruction
   pad_st_e     pad_st_q, pad_st_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  joy_state_q, joy_state_d;
   logic        joy_valid_q, joy_valid_d;

   // combo hold tracking
   key_e        cur_key_q, cur_key_d;
   logic [3:0]  hold_q, hold_d;
   logic        latch_q, latch_d;
   logic [23:0] masks_q, masks_d;

   // external button
   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic [15:0] deb_cnt_q, deb_cnt_d;
   logic        deb_lvl_q, deb_lvl_d;

   logic        req_save_q, req_save_d;
   logic        req_load_q, req_load_d;
   logic        req_menu_q, req_menu_d;

   logic        pad_hit;
   logic        mask_chg;
   key_e        key_now;
   key_e        fire;
   logic        btn_fire;

   // ---------------------------------------------------------------- pad FSM
   always_comb begin
      pad_st_d    = pad_st_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      joy_state_d = joy_state_q;
      joy_valid_d = 1'b0;
      pad_hit     = bus.bus_act && (bus.cpu_addr == 16'h4016);

      if (pad_hit && !bus.cpu_rw) begin
         if (bus.cpu_dat[0]) begin
            // strobe high restarts the pad from any state, dropping partial bits
            pad_st_d  = ST_STRB;
            bit_cnt_d = 3'd0;
            shift_d   = 8'h00;
         end else if (pad_st_q == ST_STRB) begin
            pad_st_d  = ST_SHIFT;
            bit_cnt_d = 3'd0;
            shift_d   = 8'h00;
         end
      end else if (pad_hit && bus.cpu_rw && (pad_st_q == ST_SHIFT)) begin
         // some pads report on d1 (expansion port), so either line counts as pressed
         shift_d[bit_cnt_q] = bus.cpu_dat[0] | bus.cpu_dat[1];
         bit_cnt_d          = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            joy_state_d = shift_d;
            joy_valid_d = 1'b1;
            pad_st_d    = ST_IDLE;
            bit_cnt_d   = 3'd0;
         end
      end
   end

   // ---------------------------------------------------------- combo matcher
   always_comb begin
      masks_d   = {ss_key_menu, ss_key_save, ss_key_load};
      mask_chg  = (masks_d != masks_q);
      cur_key_d = cur_key_q;
      hold_d    = hold_q;
      latch_d   = latch_q;
      fire      = K_NONE;

      // menu > save > load when several masks equal the pad byte
      if ((ss_key_menu != 8'h00) && (joy_state_q == ss_key_menu))
         key_now = K_MENU;
      else if ((ss_key_save != 8'h00) && (joy_state_q == ss_key_save))
         key_now = K_SAVE;
      else if ((ss_key_load != 8'h00) && (joy_state_q == ss_key_load))
         key_now = K_LOAD;
      else
         key_now = K_NONE;

      if (!ct_ss_on || mask_chg) begin
         // a new config invalidates any partially held combo
         cur_key_d = K_NONE;
         hold_d    = 4'd0;
         latch_d   = 1'b0;
      end else if (joy_valid_q) begin
         if (key_now == K_NONE) begin
            cur_key_d = K_NONE;
            hold_d    = 4'd0;
            latch_d   = 1'b0;
         end else if (key_now == cur_key_q) begin
            if (hold_q < HOLD_N)
               hold_d = hold_q + 4'd1;
         end else begin
            cur_key_d = key_now;
            hold_d    = 4'd1;
            latch_d   = 1'b0;
         end
         // latch keeps a held combo from re-firing every frame
         if ((key_now != K_NONE) && (hold_d == HOLD_N) && !latch_d) begin
            fire    = key_now;
            latch_d = 1'b1;
         end
      end
   end

   // ------------------------------------------------------- button debounce
   always_comb begin
      sync1_d   = ss_btn;
      sync2_d   = sync1_q;
      deb_lvl_d = deb_lvl_q;
      deb_cnt_d = 16'd0;
      btn_fire  = 1'b0;

      if (!ct_ss_on) begin
         deb_lvl_d = 1'b0;
      end else if (sync2_q != deb_lvl_q) begin
         // level is accepted on the DEB_CYC-th consecutive differing cycle
         if (deb_cnt_q == (DEB_CYC - 16'd1)) begin
            deb_lvl_d = sync2_q;
            btn_fire  = sync2_q && ct_ss_btn;
         end else begin
            deb_cnt_d = deb_cnt_q + 16'd1;
         end
      end
   end

   // ---------------------------------------------------------- request merge
   always_comb begin
      // button and menu combo collapse into one pulse; a save/load landing in the
      // same cycle as a button press yields to the menu so only one req is ever high
      req_menu_d = ct_ss_on && ((fire == K_MENU) || btn_fire);
      req_save_d = ct_ss_on && (fire == K_SAVE) && !btn_fire;
      req_load_d = ct_ss_on && (fire == K_LOAD) && !btn_fire;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pad_st_q    <= ST_IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         joy_state_q <= 8'h00;
         joy_valid_q <= 1'b0;
         cur_key_q   <= K_NONE;
         hold_q      <= 4'd0;
         latch_q     <= 1'b0;
         masks_q     <= 24'h0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         deb_cnt_q   <= 16'd0;
         deb_lvl_q   <= 1'b0;
         req_save_q  <= 1'b0;
         req_load_q  <= 1'b0;
         req_menu_q  <= 1'b0;
      end else begin
         pad_st_q    <= pad_st_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         joy_state_q <= joy_state_d;
         joy_valid_q <= joy_valid_d;
         cur_key_q   <= cur_key_d;
         hold_q      <= hold_d;
         latch_q     <= latch_d;
         masks_q     <= masks_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         deb_cnt_q   <= deb_cnt_d;
         deb_lvl_q   <= deb_lvl_d;
         req_save_q  <= req_save_d;
         req_load_q  <= req_load_d;
         req_menu_q  <= req_menu_d;
      end
   end

   assign joy_state = joy_state_q;
   assign joy_valid = joy_valid_q;
   assign req_save  = req_save_q;
   assign req_load  = req_load_q;
   assign req_menu  = req_menu_q;

endmodule

// File: tb/tb_ss_key_detect.sv
// Bench for ss_key_detect: directed pad frames, expected events queued at issue time.
// Latency: monitor samples outputs on the falling edge.
// Backpressure: none; every output event must match the head of the queue.
module tb_ss_key_detect;

   typedef enum logic [2:0] {E_NONE, E_JOY, E_SAVE, E_LOAD, E_MENU} ev_e;
   typedef struct packed {
      ev_e        kind;
      logic [7:0] dat;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] ss_key_save, ss_key_load, ss_key_menu;
   logic       ct_ss_on, ct_ss_btn, ss_btn;
   logic [7:0] joy_state;
   logic       joy_valid, req_save, req_load, req_menu;

   ev_t exp_q[$];
   int  n_chk  = 0;
   int  n_pass = 0;

   always #5 clk = ~clk;

   ss_key_detect_if bus();

   ss_key_detect #(.HOLD_FRAMES(4), .DEB_CYC(16'd20)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .ss_key_save (ss_key_save),
      .ss_key_load (ss_key_load),
      .ss_key_menu (ss_key_menu),
      .ct_ss_on    (ct_ss_on),
      .ct_ss_btn   (ct_ss_btn),
      .ss_btn      (ss_btn),
      .joy_state   (joy_state),
      .joy_valid   (joy_valid),
      .req_save    (req_save),
      .req_load    (req_load),
      .req_menu    (req_menu)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
   endtask

   task automatic pop_chk(input ev_e kind, input logic [7:0] dat);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_chk++;
         $display("FAIL spurious_event: got kind %0d with nothing expected (t=%0t)", kind, $time);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", 16'(kind), 16'(e.kind));
         if (kind == E_JOY) chk("joy_state", {8'h00, dat}, {8'h00, e.dat});
      end
   endtask

   // monitor: every asserted output consumes one expected event
   always @(negedge clk) begin
      if (rst_n) begin
         if (joy_valid) pop_chk(E_JOY, joy_state);
         if (req_menu)  pop_chk(E_MENU, 8'h00);
         if (req_save)  pop_chk(E_SAVE, 8'h00);
         if (req_load)  pop_chk(E_LOAD, 8'h00);
         if (req_menu || req_save || req_load)
            chk("req_onehot", 16'($countones({req_menu, req_save, req_load})), 16'd1);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_op(input logic [15:0] addr, input logic rw, input logic [7:0] dat);
      @(posedge clk); #1;
      bus.bus_act  = 1'b1;
      bus.cpu_addr = addr;
      bus.cpu_rw   = rw;
      bus.cpu_dat  = dat;
      @(posedge clk); #1;
      bus.bus_act  = 1'b0;
      bus.cpu_dat  = 8'h00;
   endtask

   task automatic strobe();
      bus_op(16'h4016, 1'b0, 8'h01);
      bus_op(16'h4016, 1'b0, 8'h00);
   endtask

   // pressed bits alternate between d0 and d1; released bits carry noise on d2..d7
   task automatic pad_read(input logic b, input int i);
      logic [7:0] d;
      if (b) d = (i % 2 == 1) ? 8'h02 : 8'h01;
      else   d = 8'hFC;
      bus_op(16'h4016, 1'b1, d);
   endtask

   task automatic frame(input logic [7:0] b, input ev_e req);
      exp_q.push_back('{kind: E_JOY, dat: b});
      if (req != E_NONE) exp_q.push_back('{kind: req, dat: 8'h00});
      strobe();
      for (int i = 0; i < 8; i++) begin
         pad_read(b[i], i);
         if (i == 3) bus_op(16'h4017, 1'b1, 8'h01);  // port 2 traffic must be ignored
      end
      idle(3);
   endtask

   task automatic frames(input logic [7:0] b, input int n, input ev_e last_req);
      for (int k = 0; k < n; k++) frame(b, (k == n - 1) ? last_req : E_NONE);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_joy_state"}, {8'h00, joy_state}, 16'h0000);
      chk({tag, "_joy_valid"}, {15'h0, joy_valid}, 16'h0000);
      chk({tag, "_req_save"},  {15'h0, req_save},  16'h0000);
      chk({tag, "_req_load"},  {15'h0, req_load},  16'h0000);
      chk({tag, "_req_menu"},  {15'h0, req_menu},  16'h0000);
   endtask

   task automatic press(input int cycles);
      ss_btn = 1'b1;
      idle(cycles);
      ss_btn = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.bus_act  = 1'b0;
      bus.cpu_addr = 16'h0000;
      bus.cpu_rw   = 1'b1;
      bus.cpu_dat  = 8'h00;
      ss_key_save  = 8'h00;
      ss_key_load  = 8'h00;
      ss_key_menu  = 8'h00;
      ct_ss_on     = 1'b1;
      ct_ss_btn    = 1'b0;
      ss_btn       = 1'b0;
      rst_n        = 1'b0;
      idle(3);
      chk_outputs_zero("reset");
      rst_n = 1'b1;
      idle(2);

      // basic frame: d0 = 1,0,0,1,0,0,0,0 -> 0x09
      frame(8'h09, E_NONE);
      chk("joy_state_hold", {8'h00, joy_state}, 16'h0009);
      // reads after the 8th are ignored
      bus_op(16'h4016, 1'b1, 8'h01);
      bus_op(16'h4016, 1'b1, 8'h01);
      idle(3);

      // save combo Sel+Start held: fires once on 4th frame, never again while held
      ss_key_save = 8'h0C;
      idle(2);
      frames(8'h0C, 4, E_SAVE);
      frames(8'h0C, 10, E_NONE);

      // restrobe after 3 reads: only the fresh 8 bits form the byte
      strobe();
      for (int i = 0; i < 3; i++) pad_read(1'b1, i);
      frame(8'h40, E_NONE);

      // load combo; an unrelated mask change mid-hold restarts the count
      ss_key_save = 8'h00;
      ss_key_load = 8'h81;
      idle(2);
      frames(8'h81, 2, E_NONE);
      ss_key_menu = 8'h11;
      idle(2);
      frames(8'h81, 4, E_LOAD);
      ss_key_menu = 8'h00;
      ss_key_load = 8'h00;

      // equal menu/save masks: menu wins; release re-arms
      ss_key_menu = 8'h30;
      ss_key_save = 8'h30;
      idle(2);
      frames(8'h30, 4, E_MENU);
      frames(8'h30, 2, E_NONE);
      frame(8'h00, E_NONE);
      frames(8'h30, 3, E_NONE);
      frame(8'h00, E_NONE);
      frames(8'h30, 4, E_MENU);
      ss_key_menu = 8'h00;
      ss_key_save = 8'h0C;
      idle(2);

      // hook disabled: pad still decoded, no requests; re-enable starts from zero
      ct_ss_on = 1'b0;
      frames(8'h0C, 5, E_NONE);
      ct_ss_on = 1'b1;
      frames(8'h0C, 4, E_SAVE);
      ss_key_save = 8'h00;
      idle(2);

      // external button: glitch ignored, long press fires once, release silent
      ct_ss_btn = 1'b1;
      press(10);
      idle(40);
      exp_q.push_back('{kind: E_MENU, dat: 8'h00});
      press(23);
      idle(60);
      // button not routed to menu: nothing
      ct_ss_btn = 1'b0;
      press(30);
      idle(60);

      // reset in the middle of a shift sequence
      strobe();
      for (int i = 0; i < 3; i++) pad_read(1'b1, i);
      @(posedge clk); #1;
      rst_n = 1'b0;
      idle(2);
      chk_outputs_zero("midreset");
      rst_n = 1'b1;
      idle(2);
      for (int i = 0; i < 5; i++) pad_read(1'b1, i);  // FSM idle: ignored
      idle(3);
      frame(8'h5A, E_NONE);

      idle(20);
      chk("queue_empty", 16'(exp_q.size()), 16'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
